// File: rtl/lcd_nibble_sequencer_if.sv
// Nibble output stream of lcd_nibble_sequencer: valid/ready handshake plus nibble, index and last flag.
interface lcd_nibble_sequencer_if #(
   parameter int NIB_W = 4,
   parameter int SEL_W = 3
);
   logic             out_valid;
   logic             out_ready;
   logic [NIB_W-1:0] data_out;
   logic [SEL_W-1:0] out_idx;
   logic             out_last;

   modport master (output out_valid, data_out, out_idx, out_last, input out_ready);
   modport slave  (input out_valid, data_out, out_idx, out_last, output out_ready);
endinterface

// File: rtl/lcd_nibble_sequencer.sv
// Nibble selector / sequencer for the LCD 4-bit bus: manual select or streamed word with handshake.
// Optional leading-zero blanking on MSB-first streams is enabled by defining LCD_NIBSEQ_BLANK_EN.
module lcd_nibble_sequencer #(
   parameter int               NIBBLES    = 8,
   parameter int               NIB_W      = 4,
   parameter logic [NIB_W-1:0] BLANK_CODE = NIB_W'(4'hF),
   localparam int              SEL_W      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic                     msb_first,
   input  logic                     load,
   input  logic [NIBBLES*NIB_W-1:0] data_in,
   input  logic [SEL_W-1:0]         sel,
   output logic                     busy,
   lcd_nibble_sequencer_if.master   ob
);
   typedef enum logic {IDLE, SEND} state_e;

   localparam logic [SEL_W-1:0] IDX_TOP = SEL_W'(NIBBLES - 1);

   state_e                   state_q, state_d;
   logic [NIBBLES*NIB_W-1:0] shadow_q, shadow_d;
   logic [NIBBLES-1:0]       blank_q, blank_d;
   logic                     dir_q, dir_d;
   logic [SEL_W-1:0]         idx_q, idx_d;
   logic                     valid_q, valid_d;
   logic [NIB_W-1:0]         data_q, data_d;
   logic [SEL_W-1:0]         oidx_q, oidx_d;
   logic                     last_q, last_d;

   logic [NIBBLES-1:0]       cap_blank;
   logic [SEL_W-1:0]         cap_idx;
   logic [SEL_W-1:0]         step_idx;
   logic                     xfer, is_last, capture;

   // Out-of-range indices yield 0, which covers sel >= NIBBLES in manual mode.
   function automatic logic [NIB_W-1:0] emit(input logic [NIBBLES*NIB_W-1:0] w,
                                             input logic [NIBBLES-1:0]       b,
                                             input logic [SEL_W-1:0]         i);
      emit = '0;
      for (int k = 0; k < NIBBLES; k++)
         if (i == SEL_W'(k)) emit = b[k] ? BLANK_CODE : w[k*NIB_W +: NIB_W];
   endfunction

`ifdef LCD_NIBSEQ_BLANK_EN
   // A nibble is blanked when it and every nibble above it are zero; nibble 0 always shows.
   always_comb begin
      logic seen;
      seen      = 1'b0;
      cap_blank = '0;
      for (int i = NIBBLES - 1; i >= 1; i--) begin
         if (data_in[i*NIB_W +: NIB_W] != '0) seen = 1'b1;
         cap_blank[i] = msb_first & ~seen;
      end
   end
`else
   assign cap_blank = '0;
`endif

   assign cap_idx  = msb_first ? IDX_TOP : '0;
   assign step_idx = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
   assign xfer     = valid_q & ob.out_ready & en;
   assign is_last  = (idx_q == (dir_q ? '0 : IDX_TOP));

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      blank_d  = blank_q;
      dir_d    = dir_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      data_d   = data_q;
      oidx_d   = oidx_q;
      last_d   = last_q;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!mode) begin
               valid_d = en;
               data_d  = en ? emit(data_in, '0, sel) : '0;
               oidx_d  = sel;
               last_d  = 1'b0;
            end else if (en && load) begin
               state_d = SEND;
               capture = 1'b1;
            end else begin
               valid_d = 1'b0;
               data_d  = '0;
               oidx_d  = '0;
               last_d  = 1'b0;
            end
         end
         SEND: begin
            if (!en) begin
               valid_d = 1'b0;
            end else begin
               valid_d = 1'b1;
               if (xfer && is_last) begin
                  if (load && mode) begin
                     capture = 1'b1;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                     data_d  = '0;
                     oidx_d  = '0;
                     last_d  = 1'b0;
                  end
               end else if (xfer) begin
                  idx_d  = step_idx;
                  data_d = emit(shadow_q, blank_q, step_idx);
                  oidx_d = step_idx;
                  last_d = (step_idx == (dir_q ? '0 : IDX_TOP));
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Fresh word: first nibble is presented straight from data_in so there is no bubble.
      if (capture) begin
         shadow_d = data_in;
         blank_d  = cap_blank;
         dir_d    = msb_first;
         idx_d    = cap_idx;
         valid_d  = 1'b1;
         data_d   = emit(data_in, cap_blank, cap_idx);
         oidx_d   = cap_idx;
         last_d   = (cap_idx == (msb_first ? '0 : IDX_TOP));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         blank_q  <= '0;
         dir_q    <= 1'b0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         oidx_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         blank_q  <= blank_d;
         dir_q    <= dir_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         oidx_q   <= oidx_d;
         last_q   <= last_d;
      end
   end

   assign busy         = (state_q == SEND);
   assign ob.out_valid = valid_q;
   assign ob.data_out  = data_q;
   assign ob.out_idx   = oidx_q;
   assign ob.out_last  = last_q;
endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Directed + randomized bench for lcd_nibble_sequencer (NIBBLES=8, NIB_W=4) against a word-level model.
module tb_lcd_nibble_sequencer;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst, en, mode, msb_first, load, busy;
   logic [31:0] data_in;
   logic [2:0]  sel;
   int          checks = 0;
   int          errors = 0;

   lcd_nibble_sequencer_if #(.NIB_W(4), .SEL_W(3)) bus ();

   lcd_nibble_sequencer #(.NIBBLES(N), .NIB_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .msb_first(msb_first), .load(load),
      .data_in(data_in), .sel(sel), .busy(busy), .ob(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // k-th nibble emitted for a word, from the ordering and blanking rules.
   function automatic logic [3:0] exp_nib(input logic [31:0] w, input bit msb, input int k);
      int          idx = msb ? N - 1 - k : k;
      logic [31:0] hi  = w >> (idx * 4);
      exp_nib = hi[3:0];
`ifdef LCD_NIBSEQ_BLANK_EN
      if (msb && idx > 0 && hi == 0) exp_nib = 4'hF;
`endif
   endfunction

   function automatic int exp_idx(input bit msb, input int k);
      return msb ? N - 1 - k : k;
   endfunction

   task automatic start(input logic [31:0] w, input bit msb);
      en = 1'b1; mode = 1'b1; load = 1'b1; data_in = w; msb_first = msb; bus.out_ready = 1'b0;
      step();
      load = 1'b0;
   endtask

   // rmode: 0 ready always, 1 toggling, 2 random. Optionally chains a new word on the last transfer.
   task automatic drain(input logic [31:0] w, input bit msb, input int rmode, input bit en_pulse,
                        input bit chain, input logic [31:0] cw, input bit cmsb);
      int k = 0;
      bit en_prev = 1'b1;
      bit rdy, en_c, xf;
      for (int cyc = 0; cyc < 300 && k < N; cyc++) begin
         chk("busy_in_send", busy, 1);
         chk("valid_follows_en", bus.out_valid, en_prev);
         if (bus.out_valid) begin
            chk("stream_data", bus.data_out, exp_nib(w, msb, k));
            chk("stream_idx", bus.out_idx, exp_idx(msb, k));
            chk("stream_last", bus.out_last, (k == N - 1));
         end
         rdy  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         en_c = 1'b1;
         if (en_pulse && (cyc == 3 || $urandom_range(0, 6) == 0)) en_c = 1'b0;
         xf = bus.out_valid && rdy && en_c;
         bus.out_ready = rdy;
         en = en_c;
         if (k == N - 1) begin
            mode = 1'b1;
            load = chain && xf;
            data_in = chain ? cw : $urandom;
            msb_first = chain ? cmsb : 1'($urandom_range(0, 1));
         end else begin
            // Junk on the word inputs while sending must not disturb the shadowed word.
            mode = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 1));
            data_in = $urandom;
            msb_first = 1'($urandom_range(0, 1));
         end
         if (xf) k++;
         en_prev = en_c;
         step();
      end
      chk("drain_count", k, N);
      load = 1'b0; mode = 1'b1; en = 1'b1;
      if (!chain) begin
         chk("idle_valid", bus.out_valid, 0);
         chk("idle_busy", busy, 0);
      end
   endtask

   initial begin
      logic [31:0] w;
      bit          m;
      rst = 1'b1; en = 1'b0; mode = 1'b0; msb_first = 1'b0; load = 1'b0;
      data_in = '0; sel = '0; bus.out_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.data_out, 0);
      chk("rst_idx", bus.out_idx, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      step(); step();
      rst = 1'b1;

      // Manual select
      en = 1'b1; mode = 1'b0; data_in = 32'h8765_4321; sel = 3'd5;
      step();
      chk("man_data", bus.data_out, 4'h6);
      chk("man_valid", bus.out_valid, 1);
      chk("man_idx", bus.out_idx, 5);
      en = 1'b0;
      step();
      chk("man_off_data", bus.data_out, 0);
      chk("man_off_valid", bus.out_valid, 0);
      for (int i = 0; i < 12; i++) begin
         data_in = $urandom; sel = 3'($urandom_range(0, 7)); en = ($urandom_range(0, 3) != 0);
         load = 1'($urandom_range(0, 1)); bus.out_ready = 1'($urandom_range(0, 1));
         step();
         chk("man_rand_data", bus.data_out, en ? 32'((data_in >> (sel * 4)) & 32'hF) : 32'h0);
         chk("man_rand_valid", bus.out_valid, en);
         chk("man_rand_idx", bus.out_idx, sel);
         chk("man_rand_last", bus.out_last, 0);
         chk("man_rand_busy", busy, 0);
      end
      load = 1'b0;

      // Stream MSB-first, full throughput
      start(32'h1234_ABCD, 1'b1);
      drain(32'h1234_ABCD, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

      // LSB-first with toggling ready and an enable pulse
      start(32'h1234_ABCD, 1'b0);
      drain(32'h1234_ABCD, 1'b0, 1, 1'b1, 1'b0, '0, 1'b0);

      // Back-to-back word on the last transfer
      start(32'hFFFF_FFFF, 1'b1);
      drain(32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b1, 32'h0000_0001, 1'b1);
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_idx", bus.out_idx, 7);
      chk("b2b_data", bus.data_out, exp_nib(32'h0000_0001, 1'b1, 0));
      drain(32'h0000_0001, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

      // Leading-zero words
      start(32'h0000_0A05, 1'b1);
      drain(32'h0000_0A05, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
      start(32'h0000_0000, 1'b1);
      drain(32'h0000_0000, 1'b1, 2, 1'b0, 1'b0, '0, 1'b0);
      start(32'h0000_0A05, 1'b0);
      drain(32'h0000_0A05, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);

      // Randomized streams
      for (int i = 0; i < 6; i++) begin
         w = $urandom;
         if (i == 2) w = w & 32'h0000_0FFF;
         m = 1'($urandom_range(0, 1));
         start(w, m);
         drain(w, m, 2, 1'b1, 1'b0, '0, 1'b0);
      end

      // Async reset in the middle of a word
      start(32'h1234_ABCD, 1'b1);
      bus.out_ready = 1'b1;
      step(); step(); step();
      chk("pre_rst_data", bus.data_out, 4'h4);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", bus.data_out, 0);
      step(); step();
      rst = 1'b1;
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", bus.out_valid, 0);
      w = $urandom;
      start(w, 1'b1);
      chk("post_rst_idx", bus.out_idx, 7);
      drain(w, 1'b1, 2, 1'b0, 1'b0, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
